disp_vramrd: RTL
================

Name: disp_vramrd

Overview:
- AXI4 read master that fetches one display frame from VRAM and writes it into the display pixel FIFO (FIFOWR/FIFOIN writer side).
- One 64-bit beat carries two 24-bit pixels: bits [55:32] hold the first pixel and bits [23:0] the second; the block passes data through unmodified.
- Sits in the ACLK domain between the AXI interconnect and the pixel FIFO.
- Paces bursts by FIFO room, so the display side never underflows while DISPON is held.

Parameters:
- HPIX, 640, active pixels per line.
- VPIX, 480, active lines per frame.
- BURST_LEN, 16, beats per AXI burst; must be a power of 2 and ≤16; (HPIX*VPIX/2) % BURST_LEN == 0.
- ADDR_W, 32, AXI address width.

Ports:
- ACLK  in  1  system clock.
- ARSTN  in  1  asynchronous active-low reset.
- DISPON  in  1  display enable (level).
- VSTART  in  1  one-cycle frame-start pulse, already synchronized to ACLK.
- DISPADDR  in  ADDR_W  frame base address; sampled at frame start.
- BUF_WREADY  in  1  FIFO has room for at least one full burst.
- ARADDR  out  ADDR_W  burst address.
- ARLEN  out  8  constant BURST_LEN-1.
- ARVALID  out  1  address valid.
- ARREADY  in  1  address accepted.
- RDATA  in  64  read data.
- RRESP  in  2  read response.
- RLAST  in  1  last beat of burst.
- RVALID  in  1  data valid.
- RREADY  out  1  data ready.
- FIFOWR  out  1  FIFO write strobe.
- FIFOIN  out  64  FIFO write data.
- BUSY  out  1  frame transfer in progress.
- FRAME_DONE  out  1  one-cycle pulse after the final beat of a frame.

Behaviour:
- Reset (ARSTN=0, async): state IDLE; ARVALID, RREADY, FIFOWR, BUSY and FRAME_DONE = 0; ARADDR and FIFOIN = 0; all counters = 0.
- Constants:
  - NBURST = HPIX*VPIX/(2*BURST_LEN); default is 9600.
  - Burst stride = BURST_LEN*8 bytes; default is 128.
- FSM states: IDLE → WAITBUF → ADDR → DATA → WAITBUF or IDLE.
- IDLE:
  - VSTART=1 and DISPON=1 → latch base = DISPADDR with the low log2(BURST_LEN*8) bits forced to 0, so no burst crosses a 4 KB boundary.
  - Same cycle: clear the burst counter and go to WAITBUF.
  - VSTART with DISPON=0 is ignored.
- WAITBUF: BUF_WREADY=1 → ADDR. ARVALID rises on the next cycle with ARADDR = base + burst_cnt*stride.
- ADDR:
  - ARVALID and ARADDR are held stable until ARREADY=1.
  - On the handshake, drop ARVALID and go to DATA.
  - Only one burst is outstanding at a time.
- DATA:
  - RREADY=1 for the whole state.
  - Each beat with RVALID&RREADY: next cycle FIFOWR=1 and FIFOIN=RDATA (registered, 1-cycle latency).
  - No other cycle asserts FIFOWR.
- On the RLAST beat:
  - If burst_cnt == NBURST-1 → IDLE and pulse FRAME_DONE on the cycle after the last FIFOWR.
  - Else burst_cnt++. Go to IDLE if DISPON=0, otherwise WAITBUF.
- DISPON falling mid-frame:
  - An in-flight AR or burst is completed; AXI transfers are never abandoned.
  - After that burst the FSM returns to IDLE with no FRAME_DONE pulse.
- VSTART outside IDLE is ignored; a missed frame start is not queued.
- RLAST on a beat other than number BURST_LEN: that beat still ends the burst. The beat counter is not checked unless the optional feature is compiled in.
- Address arithmetic is modulo 2^ADDR_W.
- BUSY = (state != IDLE).
- Reset mid-burst: everything returns to reset values immediately. The AXI side is expected to be reset at the same time.

Optional Feature:
- Macro DISP_VRAMRD_ERRCHK_EN.
- Defined:
  - Adds output RERR (1-bit, sticky) and ERRCNT (8-bit, saturating at 255).
  - Each RVALID&RREADY beat with RRESP != 0, or RLAST on a beat other than number BURST_LEN, sets RERR and increments ERRCNT.
  - Both are cleared only by reset or by a VSTART accepted in IDLE.
- Not defined: ports absent, no checking logic.

Decomposition:
- Package disp_vramrd_pkg holds:
  - state encoding (IDLE=0, WAITBUF=1, ADDR=2, DATA=3);
  - RRESP_OKAY constant;
  - stride and NBURST derived-constant functions.
- Sub-module disp_vramrd_addrgen: base latch, burst counter, ARADDR computation, last-burst flag. Keeps the FSM file small.

Test Plan:
- HPIX=32, VPIX=2, BURST_LEN=16, DISPADDR=0x2000_0000, VSTART with slave ARREADY=1 → exactly 2 ARs at 0x2000_0000 and 0x2000_0080 with ARLEN=15; 32 FIFOWR pulses with FIFOIN equal to RDATA in order; one FRAME_DONE.
- BUF_WREADY held 0 for 50 cycles after VSTART → ARVALID stays 0. BUF_WREADY=1 → ARVALID rises the next cycle.
- ARREADY delayed 7 cycles → ARVALID and ARADDR stable all 7 cycles; exactly one AR handshake.
- RVALID gapped (1 of every 3 cycles) → FIFOWR mirrors each beat 1 cycle later, never doubled.
- DISPON dropped during burst 1 of 2 → burst 1 completes all 16 FIFOWR; no second AR; no FRAME_DONE; BUSY=0 afterwards.
- With DISP_VRAMRD_ERRCHK_EN: RRESP=2 on beat 5 → RERR=1, ERRCNT=1, and all 16 beats are still written to the FIFO.

Source files
------------

// File: rtl/disp_vramrd_pkg.sv
// disp_vramrd_pkg: shared definitions for the VRAM frame read master.
//   state_t       FSM state encoding (IDLE=0, WAITBUF=1, ADDR=2, DATA=3)
//   RRESP_OKAY    AXI OKAY response code
//   stride_bytes  address step between consecutive bursts
//   nburst        number of bursts that make up one frame
package disp_vramrd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITBUF = 2'd1,
    ST_ADDR    = 2'd2,
    ST_DATA    = 2'd3
  } state_t;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  // One AXI beat is 64 bits wide and carries two 24-bit pixels.
  localparam int BEAT_BYTES = 8;

  function automatic int stride_bytes(input int burst_len);
    return burst_len * BEAT_BYTES;
  endfunction

  function automatic int nburst(input int hpix, input int vpix, input int burst_len);
    return (hpix * vpix) / (2 * burst_len);
  endfunction

endpackage

// File: rtl/disp_vramrd_addrgen.sv
// disp_vramrd_addrgen: frame base latch, burst counter and burst address.
// Ports:
//   ACLK, ARSTN  clock, asynchronous active-low reset
//   start        frame accepted: latch aligned base, clear burst counter
//   base_in      frame base address (DISPADDR)
//   ld_addr      load araddr for the burst about to be requested
//   advance      a non-final burst has finished; step the burst counter
//   araddr       address of the current burst (held between loads)
//   last_burst   current burst is the final one of the frame
module disp_vramrd_addrgen
  import disp_vramrd_pkg::*;
#(
  parameter int HPIX      = 640,
  parameter int VPIX      = 480,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              ACLK,
  input  logic              ARSTN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_in,
  input  logic              ld_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] araddr,
  output logic              last_burst
);

  localparam int NBURST = nburst(HPIX, VPIX, BURST_LEN);
  localparam int STRIDE = stride_bytes(BURST_LEN);
  localparam int SHIFT  = $clog2(STRIDE);
  localparam int CNT_W  = (NBURST > 1) ? $clog2(NBURST) : 1;

  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(NBURST - 1);
  // Forcing the base onto a burst-size boundary keeps every burst inside
  // one 4 KB page, since the stride is a power of two no larger than 128.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRIDE - 1);

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  burst_cnt;
  logic [ADDR_W-1:0] offset;

  // Address wraps modulo 2^ADDR_W by construction of the adder width.
  assign offset     = ADDR_W'(burst_cnt) << SHIFT;
  assign last_burst = (burst_cnt == LAST_CNT);

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      base_q    <= '0;
      burst_cnt <= '0;
      araddr    <= '0;
    end else begin
      if (start) begin
        base_q    <= base_in & ALIGN_MASK;
        burst_cnt <= '0;
      end else if (advance) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (ld_addr) begin
        araddr <= base_q + offset;
      end
    end
  end

endmodule

// File: rtl/disp_vramrd.sv
// disp_vramrd: AXI4 read master that streams one display frame from VRAM
// into the display pixel FIFO. One burst is outstanding at a time and a new
// burst is only requested when the FIFO reports room for a full burst.
// Ports:
//   ACLK, ARSTN            clock, asynchronous active-low reset
//   DISPON, VSTART         display enable (level), frame start pulse
//   DISPADDR               frame base address, sampled at frame start
//   BUF_WREADY             FIFO can take one full burst
//   AR*/R*                 AXI4 read address / read data channels
//   FIFOWR, FIFOIN         FIFO write strobe and data (RDATA delayed 1 cycle)
//   BUSY                   frame transfer in progress
//   FRAME_DONE             pulse the cycle after the final FIFO write
// Optional (macro DISP_VRAMRD_ERRCHK_EN):
//   RERR                   sticky error flag (bad RRESP or early RLAST)
//   ERRCNT                 saturating error count
module disp_vramrd
  import disp_vramrd_pkg::*;
#(
  parameter int HPIX      = 640,
  parameter int VPIX      = 480,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              ACLK,
  input  logic              ARSTN,
  input  logic              DISPON,
  input  logic              VSTART,
  input  logic [ADDR_W-1:0] DISPADDR,
  input  logic              BUF_WREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [63:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              FIFOWR,
  output logic [63:0]       FIFOIN,
  output logic              BUSY,
  output logic              FRAME_DONE
`ifdef DISP_VRAMRD_ERRCHK_EN
  ,
  output logic              RERR,
  output logic [7:0]        ERRCNT
`endif
);

  state_t state, state_nxt;

  logic frame_start;
  logic ld_addr;
  logic beat;
  logic burst_end;
  logic last_burst;
  logic advance;

  logic        vld_p1;
  logic [63:0] fifoin_p1;
  logic        done_p1;
  logic        done_p2;

  assign frame_start = (state == ST_IDLE) & VSTART & DISPON;
  assign ld_addr     = (state == ST_WAITBUF) & BUF_WREADY;
  assign beat        = (state == ST_DATA) & RVALID;
  // Any RLAST ends the burst, whatever the beat count.
  assign burst_end   = beat & RLAST;
  assign advance     = burst_end & ~last_burst;

  assign ARLEN = 8'(BURST_LEN - 1);

  disp_vramrd_addrgen #(
    .HPIX      (HPIX),
    .VPIX      (VPIX),
    .BURST_LEN (BURST_LEN),
    .ADDR_W    (ADDR_W)
  ) u_addrgen (
    .ACLK       (ACLK),
    .ARSTN      (ARSTN),
    .start      (frame_start),
    .base_in    (DISPADDR),
    .ld_addr    (ld_addr),
    .advance    (advance),
    .araddr     (ARADDR),
    .last_burst (last_burst)
  );

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DISPON is only consulted at burst boundaries so an accepted AR or a
  // running burst is always carried through to RLAST.
  always_comb begin
    state_nxt = state;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    BUSY      = 1'b1;
    case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (VSTART && DISPON) state_nxt = ST_WAITBUF;
      end
      ST_WAITBUF: begin
        if (BUF_WREADY) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) begin
          state_nxt = (last_burst || !DISPON) ? ST_IDLE : ST_WAITBUF;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: registered FIFO write; p2: frame-done one cycle after it.
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      vld_p1    <= 1'b0;
      fifoin_p1 <= '0;
      done_p1   <= 1'b0;
      done_p2   <= 1'b0;
    end else begin
      vld_p1  <= beat;
      if (beat) fifoin_p1 <= RDATA;
      done_p1 <= burst_end & last_burst;
      done_p2 <= done_p1;
    end
  end

  assign FIFOWR     = vld_p1;
  assign FIFOIN     = fifoin_p1;
  assign FRAME_DONE = done_p2;

`ifdef DISP_VRAMRD_ERRCHK_EN
  localparam int BCNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_LEN - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [BCNT_W-1:0] beat_cnt;
  logic              beat_err;
  logic              rerr_q;
  logic [7:0]        errcnt_q;

  assign beat_err = beat & ((RRESP != RRESP_OKAY) | (RLAST & (beat_cnt != BEAT_LAST)));

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      beat_cnt <= '0;
      rerr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      // Counter saturates so an over-long burst cannot alias back to a
      // legal beat position.
      if (state != ST_DATA) begin
        beat_cnt <= '0;
      end else if (beat) begin
        if (RLAST) beat_cnt <= '0;
        else if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      end
      if (frame_start) begin
        rerr_q   <= 1'b0;
        errcnt_q <= '0;
      end else if (beat_err) begin
        rerr_q   <= 1'b1;
        errcnt_q <= sat_inc8(errcnt_q);
      end
    end
  end

  assign RERR   = rerr_q;
  assign ERRCNT = errcnt_q;
`else
  // Response code is only inspected by the error checker.
  logic unused_rresp;
  assign unused_rresp = ^RRESP;
`endif

endmodule
